// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared constants for the ALU round-robin arbiter/sequencer
package alu_arb_pkg;

    localparam int DEF_OP_W   = 3;
    localparam int DEF_DATA_W = 8;

    // Sequencer states
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;

    // Requester IDs
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant from valids and the last grant
module rr_arbiter2
    import alu_arb_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant
);

    // A lone requester always wins; under contention the one not served last wins
    always_comb begin
        grant_valid = valid0 | valid1;
        grant       = REQ0;
        if (valid0 && valid1) begin
            grant = ~last_grant;
        end else if (valid1) begin
            grant = REQ1;
        end
    end

endmodule

// File: rtl/alu8bit_arbiter.sv
// rtl/alu8bit_arbiter.sv - two-requester sequencer for the shared ALU (optional ALU_ARB_STATS_EN)
module alu8bit_arbiter
    import alu_arb_pkg::*;
#(
    parameter int OP_W   = DEF_OP_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [OP_W-1:0]     req0_opcode,
    input  logic [DATA_W-1:0]   req0_a,
    input  logic [DATA_W-1:0]   req0_b,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [OP_W-1:0]     req1_opcode,
    input  logic [DATA_W-1:0]   req1_a,
    input  logic [DATA_W-1:0]   req1_b,
    output logic [OP_W-1:0]     alu_opcode,
    output logic [DATA_W-1:0]   alu_op1,
    output logic [DATA_W-1:0]   alu_op2,
    input  logic [2*DATA_W-1:0] alu_result,
    input  logic                alu_flagC,
    input  logic                alu_flagZ,
    output logic                rsp_valid,
    output logic                rsp_id,
    output logic [2*DATA_W-1:0] rsp_result,
    output logic                rsp_c,
    output logic                rsp_z
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]         stat_cnt0,
    output logic [15:0]         stat_cnt1
`endif
);

    logic [1:0] state;
    logic       last_grant;
    logic       grant;
    logic       grant_valid;
    logic       fire;

    rr_arbiter2 u_rr (
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    // Only IDLE accepts work; the arbiter guarantees at most one ready
    assign fire       = (state == IDLE) && grant_valid;
    assign req0_ready = (state == IDLE) && req0_valid && (grant == REQ0);
    assign req1_ready = (state == IDLE) && req1_valid && (grant == REQ1);

    // Sequencer: latch operands on accept, wait one cycle for the ALU, capture result.
    // last_grant doubles as the owner ID of the in-flight op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= REQ1;
            alu_opcode <= '0;
            alu_op1    <= '0;
            alu_op2    <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= REQ0;
            rsp_result <= '0;
            rsp_c      <= 1'b0;
            rsp_z      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (fire) begin
                        last_grant <= grant;
                        alu_opcode <= grant ? req1_opcode : req0_opcode;
                        alu_op1    <= grant ? req1_a : req0_a;
                        alu_op2    <= grant ? req1_b : req0_b;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    rsp_valid  <= 1'b1;
                    rsp_id     <= last_grant;
                    rsp_result <= alu_result;
                    rsp_c      <= alu_flagC;
                    rsp_z      <= alu_flagZ;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    // Per-requester completed-response counters, saturating at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_cnt0 <= 16'h0000;
            stat_cnt1 <= 16'h0000;
        end else if (rsp_valid) begin
            if (rsp_id == REQ0 && stat_cnt0 != 16'hFFFF) begin
                stat_cnt0 <= stat_cnt0 + 16'd1;
            end
            if (rsp_id == REQ1 && stat_cnt1 != 16'hFFFF) begin
                stat_cnt1 <= stat_cnt1 + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu8bit_arbiter.sv
// tb/tb_alu8bit_arbiter.sv - self-checking bench for alu8bit_arbiter
module tb_alu8bit_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_opcode = '0, req1_opcode = '0, alu_opcode;
    logic [7:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [7:0]  alu_op1, alu_op2;
    logic [15:0] alu_result, rsp_result;
    logic        alu_flagC, alu_flagZ, rsp_valid, rsp_id, rsp_c, rsp_z;
`ifdef ALU_ARB_STATS_EN
    logic [15:0] stat_cnt0, stat_cnt1;
`endif

    alu8bit_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_opcode (req0_opcode),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_opcode (req1_opcode),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .alu_opcode  (alu_opcode),
        .alu_op1     (alu_op1),
        .alu_op2     (alu_op2),
        .alu_result  (alu_result),
        .alu_flagC   (alu_flagC),
        .alu_flagZ   (alu_flagZ),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_c       (rsp_c),
        .rsp_z       (rsp_z)
`ifdef ALU_ARB_STATS_EN
        ,
        .stat_cnt0   (stat_cnt0),
        .stat_cnt1   (stat_cnt1)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in combinational ALU: {carry, zero, result}
    function automatic logic [17:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] r;
        logic        c;
        c = 1'b0;
        case (op)
            3'd0: begin r = 16'(a) + 16'(b); c = r[8]; end
            3'd1: begin r = {8'h00, a - b}; c = (a < b); end
            3'd2: r = {8'h00, a & b};
            3'd3: r = {8'h00, a | b};
            3'd4: r = {8'h00, a ^ b};
            3'd5: begin r = 16'(a) * 16'(b); c = |r[15:8]; end
            3'd6: r = 16'(a) << b[2:0];
            default: r = {8'h00, a};
        endcase
        return {c, (r == 16'h0000), r};
    endfunction

    assign {alu_flagC, alu_flagZ, alu_result} = alu_f(alu_opcode, alu_op1, alu_op2);

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          due;
        logic        id;
        logic [15:0] res;
        logic        c;
        logic        z;
    } rsp_t;

    rsp_t        expq[$];
    int          last_hs;
    logic        last_id;
    logic [2:0]  m_op;
    logic [7:0]  m_a, m_b;
    logic        m_rid, m_c, m_z;
    logic [15:0] m_res;
    int          n_rsp0, n_rsp1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        last_hs = -100;
        last_id = 1'b1;
        expq.delete();
        m_op = '0; m_a = '0; m_b = '0;
        m_rid = 1'b0; m_res = '0; m_c = 1'b0; m_z = 1'b0;
        n_rsp0 = 0; n_rsp1 = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One clock of checking: called at a negedge after inputs are set, returns at the next negedge.
    // Model: an accept at edge E yields a response visible after edge E+2, and the next
    // accept may happen no earlier than edge E+3; ties go to whoever was not served last.
    task automatic step(output bit acc0, output bit acc1);
        bit          free, e0, e1, due;
        rsp_t        r;
        logic [17:0] f;
        #1;
        free = (cyc >= last_hs + 2);
        e0 = free && req0_valid && (!req1_valid || last_id == 1'b1);
        e1 = free && req1_valid && (!req0_valid || last_id == 1'b0);
        chk("req0_ready", req0_ready, e0);
        chk("req1_ready", req1_ready, e1);
        due = (expq.size() > 0) && (expq[0].due == cyc);
        if (due) begin
            r = expq.pop_front();
            m_rid = r.id; m_res = r.res; m_c = r.c; m_z = r.z;
            if (r.id) n_rsp1++; else n_rsp0++;
        end
        chk("rsp_valid", rsp_valid, due);
        chk("rsp_id", rsp_id, m_rid);
        chk("rsp_result", rsp_result, m_res);
        chk("rsp_c", rsp_c, m_c);
        chk("rsp_z", rsp_z, m_z);
        chk("alu_opcode", alu_opcode, m_op);
        chk("alu_op1", alu_op1, m_a);
        chk("alu_op2", alu_op2, m_b);
        if (e0 || e1) begin
            last_hs = cyc + 1;
            last_id = e1;
            m_op = e1 ? req1_opcode : req0_opcode;
            m_a  = e1 ? req1_a : req0_a;
            m_b  = e1 ? req1_b : req0_b;
            f = alu_f(m_op, m_a, m_b);
            r.due = cyc + 3; r.id = e1; r.c = f[17]; r.z = f[16]; r.res = f[15:0];
            expq.push_back(r);
        end
        acc0 = e0;
        acc1 = e1;
        @(negedge clk);
    endtask

    typedef struct {
        bit         v0;
        bit         v1;
        logic [2:0] op0;
        logic [7:0] a0, b0;
        logic [2:0] op1;
        logic [7:0] a1, b1;
        bit         exp_id;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc0, acc1, got;
        int prev, n;
        model_reset();
        tbl[0] = '{1, 0, 3'd2, 8'hAA, 8'h55, 3'd0, 8'h00, 8'h00, 0};
        tbl[1] = '{0, 1, 3'd0, 8'h00, 8'h00, 3'd0, 8'hFF, 8'h01, 1};
        tbl[2] = '{1, 1, 3'd1, 8'h10, 8'h20, 3'd5, 8'h12, 8'h34, 0};
        tbl[3] = '{1, 0, 3'd4, 8'h5A, 8'h5A, 3'd0, 8'h00, 8'h00, 0};
        tbl[4] = '{1, 1, 3'd3, 8'h0F, 8'hF0, 3'd6, 8'h81, 8'h07, 1};
        tbl[5] = '{0, 1, 3'd0, 8'h00, 8'h00, 3'd7, 8'h00, 8'h00, 1};
        tbl[6] = '{1, 1, 3'd5, 8'hFF, 8'hFF, 3'd1, 8'h00, 8'h01, 0};
        tbl[7] = '{1, 0, 3'd7, 8'hFF, 8'hFF, 3'd0, 8'h00, 8'h00, 0};

        do_reset();
        repeat (10) step(acc0, acc1);

        // Directed table: first grant per row, then the loser (if any) is served next
        foreach (tbl[i]) begin
            req0_valid = tbl[i].v0; req0_opcode = tbl[i].op0; req0_a = tbl[i].a0; req0_b = tbl[i].b0;
            req1_valid = tbl[i].v1; req1_opcode = tbl[i].op1; req1_a = tbl[i].a1; req1_b = tbl[i].b1;
            got = 0;
            for (int k = 0; k < 8 && !got; k++) begin
                step(acc0, acc1);
                if (acc0 || acc1) begin
                    got = 1;
                    chk("tbl_first_id", acc1, tbl[i].exp_id);
                    if (acc0) req0_valid = 1'b0; else req1_valid = 1'b0;
                end
            end
            chk("tbl_accept_seen", got, 1);
            if (req0_valid || req1_valid) begin
                got = 0;
                for (int k = 0; k < 8 && !got; k++) begin
                    step(acc0, acc1);
                    if (acc0 || acc1) begin
                        got = 1;
                        chk("tbl_second_id", acc1, !tbl[i].exp_id);
                    end
                end
                chk("tbl_second_seen", got, 1);
            end
            req0_valid = 1'b0; req1_valid = 1'b0;
            repeat (3) step(acc0, acc1);
        end

        // Reset during ISSUE: in-flight op discarded, reset values appear asynchronously
        req0_valid = 1'b1; req0_opcode = 3'd3; req0_a = 8'hC3; req0_b = 8'h3C;
        step(acc0, acc1);
        chk("midrst_accept", acc0, 1);
        req0_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_async_op1", alu_op1, 8'h00);
        chk("midrst_async_opcode", alu_opcode, 3'd0);
        chk("midrst_async_rsp_valid", rsp_valid, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("midrst_rsp_valid", rsp_valid, 0);
        end
        rst = 1'b0;
        model_reset();
        req0_valid = 1'b1; req0_opcode = 3'd0; req0_a = 8'h11; req0_b = 8'h22;
        req1_valid = 1'b1; req1_opcode = 3'd0; req1_a = 8'h33; req1_b = 8'h44;
        step(acc0, acc1);
        chk("postrst_req0_first", acc0, 1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) step(acc0, acc1);

        // Contention from reset: strict alternation, one accept every 3 cycles
        do_reset();
        req0_valid = 1'b1; req0_opcode = 3'd0; req0_a = 8'h01; req0_b = 8'h02;
        req1_valid = 1'b1; req1_opcode = 3'd0; req1_a = 8'h80; req1_b = 8'h90;
        n = 0; prev = -1;
        for (int k = 0; k < 40 && n < 8; k++) begin
            step(acc0, acc1);
            if (acc0 || acc1) begin
                chk("contend_order", acc1, n % 2);
                if (prev >= 0) chk("contend_gap", cyc - prev, 3);
                prev = cyc;
                if (acc0) begin req0_a = req0_a + 8'd1; req0_opcode = req0_opcode + 3'd1; end
                else begin req1_a = req1_a + 8'd1; req1_opcode = req1_opcode + 3'd2; end
                n++;
            end
        end
        chk("contend_count", n, 8);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) step(acc0, acc1);

        // Sole requester streaming opcodes 0..5
        req1_valid = 1'b1; req1_opcode = 3'd0; req1_a = 8'h77; req1_b = 8'h0A;
        n = 0; prev = -1;
        for (int k = 0; k < 40 && n < 6; k++) begin
            step(acc0, acc1);
            if (acc1) begin
                if (prev >= 0) chk("stream_gap", cyc - prev, 3);
                prev = cyc;
                n++;
                req1_opcode = 3'(n);
                if (n == 6) req1_valid = 1'b0;
            end
        end
        chk("stream_count", n, 6);
        repeat (4) step(acc0, acc1);

        // Randomized traffic with protocol-correct requesters
        for (int k = 0; k < 400; k++) begin
            if (!req0_valid && $urandom_range(0, 2) == 0) begin
                req0_valid = 1'b1; req0_opcode = 3'($urandom); req0_a = 8'($urandom); req0_b = 8'($urandom);
            end
            if (!req1_valid && $urandom_range(0, 2) == 0) begin
                req1_valid = 1'b1; req1_opcode = 3'($urandom); req1_a = 8'($urandom); req1_b = 8'($urandom);
            end
            step(acc0, acc1);
            if (acc0) req0_valid = 1'b0;
            if (acc1) req1_valid = 1'b0;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (5) step(acc0, acc1);
        chk("drain_empty", expq.size(), 0);

`ifdef ALU_ARB_STATS_EN
        do_reset();
        chk("stat0_reset", stat_cnt0, 0);
        for (int k = 0; k < 5; k++) begin
            if (k < 3) begin req0_valid = 1'b1; req0_a = 8'(k); end
            else begin req1_valid = 1'b1; req1_a = 8'(k); end
            got = 0;
            for (int j = 0; j < 8 && !got; j++) begin
                step(acc0, acc1);
                got = acc0 || acc1;
            end
            req0_valid = 1'b0; req1_valid = 1'b0;
        end
        repeat (5) step(acc0, acc1);
        chk("stat_cnt0", stat_cnt0, 3);
        chk("stat_cnt1", stat_cnt1, 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu8bit_arbiter.md
Name: alu8bit_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for the shared 8-bit ALU (3-bit opcode, two 8-bit operands, 16-bit result, carry and zero flags).
- Accepts one operation at a time over a valid/ready handshake.
- Drives the ALU from registered operands and captures result and flags one cycle later.
- Returns them on a shared response bus tagged with the requester ID.
- Sits between the two client blocks and the purely combinational ALU instance.

Parameters:
OP_W, 3, opcode width (fixed by ALU)
DATA_W, 8, operand width; result width is 2*DATA_W

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 accepted this cycle
req0_opcode  input  OP_W  requester 0 opcode
req0_a  input  DATA_W  requester 0 operand1
req0_b  input  DATA_W  requester 0 operand2
req1_valid / req1_ready / req1_opcode / req1_a / req1_b  same widths, requester 1
alu_opcode  output  OP_W  to ALU opcode
alu_op1  output  DATA_W  to ALU operand1
alu_op2  output  DATA_W  to ALU operand2
alu_result  input  2*DATA_W  from ALU result
alu_flagC  input  1  from ALU carry flag
alu_flagZ  input  1  from ALU zero flag
rsp_valid  output  1  one-cycle response pulse
rsp_id  output  1  requester that owns the response
rsp_result  output  2*DATA_W  captured result
rsp_c  output  1  captured carry
rsp_z  output  1  captured zero

Behaviour:
- Clocking/reset: single clock, asynchronous active-high reset.
- FSM states: IDLE, ISSUE, CAPTURE.
- Reset values: state=IDLE, last_grant=1 (so requester 0 wins first), alu_opcode/op1/op2=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_c=0, rsp_z=0.
- Arbitration in IDLE (combinational):
  - Only one valid: grant it.
  - Both valid: grant !last_grant.
  - Neither valid: stay IDLE.
- reqN_ready = (state==IDLE) && reqN_valid && grant==N. At most one ready high per cycle; ready is never high outside IDLE.
- Handshake: a transfer occurs when valid && ready.
  - On that edge: latch opcode/a/b into the alu_* registers, latch the ID, set last_grant=ID, go to ISSUE.
  - Requesters hold valid and payload stable until ready.
- ISSUE (1 cycle): alu_* outputs stable; ALU settles combinationally. Next state is CAPTURE.
- CAPTURE edge: register alu_result/flagC/flagZ into rsp_*, assert rsp_valid for exactly one cycle, return to IDLE.
- Latency: handshake at edge t → rsp_valid high during cycle t+2.
- Throughput: one operation per 3 cycles.
- rsp_* data holds its last value after rsp_valid drops. rsp_valid has no backpressure.
- alu_* outputs hold the last issued operation while in IDLE, so the ALU input never glitches.
- Boundaries:
  - Back-to-back requests from the same sole requester are granted every 3 cycles.
  - With both requesters continuously valid, grants alternate strictly 0,1,0,1.
- Reset mid-operation: the in-flight op is discarded, no rsp_valid is produced, the FSM returns to IDLE with reset values.

Optional Feature:
Macro ALU_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_cnt0 and stat_cnt1 (16 bits each), reset to 0.
  - Each increments on a completed response (rsp_valid) for its ID.
  - Each saturates at 16'hFFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package alu_arb_pkg:
  - State encoding constants: IDLE=2'd0, ISSUE=2'd1, CAPTURE=2'd2.
  - OP_W and DATA_W defaults.
  - Requester ID constants REQ0=1'b0, REQ1=1'b1.
- One natural sub-module, rr_arbiter2: 2-way round-robin grant logic from valids plus last_grant.
- FSM and datapath registers stay in the top module.

Test Plan:
- Reset then idle: both valid=0 for 10 cycles → all outputs at reset values, no ready, no rsp_valid.
- Single request: req0 opcode=3'd2, a=8'hAA, b=8'h55 → req0_ready the same cycle; next cycle alu_opcode=2, alu_op1=AA, alu_op2=55; two cycles after the handshake, rsp_valid=1, rsp_id=0, rsp_result/c/z equal the ALU outputs sampled in ISSUE.
- Contention: both valid from reset, each holding valid through 4 ops (req0 a=8'h01.., req1 a=8'h80..) → grant order 0,1,0,1, rsp_id sequence 0,1,0,1, each response spaced 3 cycles apart.
- Sole requester streaming: req1 valid for 6 ops, opcodes 0..5 → ready every 3rd cycle, opcode order preserved in alu_opcode.
- Reset mid-op: assert rst during ISSUE → rsp_valid never asserted for that op; after release, req0 is granted first.
- With ALU_ARB_STATS_EN: 3 ops from req0 and 2 from req1 → stat_cnt0=3, stat_cnt1=2; force stat_cnt0 preload to FFFF via 65535 ops in fast mode → it stays at FFFF.
